// File: rtl/ecap5_dwbmem_bram_mp.sv
// Multi-port Wishbone B4 pipelined BRAM: NUM_PORTS slaves share one byte-writable RAM via round-robin stall arbitration.
// Define ECAP5_DWBMEM_BRAM_OUTREG_EN to add a read-data output register (ack latency 2 instead of 1).
module ecap5_dwbmem_bram_mp #(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_PORTS*32-1:0] wb_adr_i,
  input  logic [NUM_PORTS*32-1:0] wb_dat_i,
  input  logic [NUM_PORTS*4-1:0]  wb_sel_i,
  input  logic [NUM_PORTS-1:0]    wb_we_i,
  input  logic [NUM_PORTS-1:0]    wb_stb_i,
  input  logic [NUM_PORTS-1:0]    wb_cyc_i,
  output logic [NUM_PORTS*32-1:0] wb_dat_o,
  output logic [NUM_PORTS-1:0]    wb_ack_o,
  output logic [NUM_PORTS-1:0]    wb_stall_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int RR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
`ifdef ECAP5_DWBMEM_BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;
  logic                 gnt_any;
  logic [RR_W-1:0]      rr_q, rr_d;
  int                   j;

  assign req        = wb_cyc_i & wb_stb_i;
  assign wb_stall_o = req & ~grant;

  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    rr_d    = rr_q;
    j       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = (int'(rr_q) + i) % NUM_PORTS;
      if (!gnt_any && req[j]) begin
        grant[j] = 1'b1;
        gnt_any  = 1'b1;
        rr_d     = (j == NUM_PORTS - 1) ? '0 : RR_W'(j + 1);
      end
    end
  end

  logic [31:0]       m_adr, m_dat;
  logic [3:0]        m_sel;
  logic              m_we;
  logic [ADDR_W-1:0] m_idx;
  logic              unused_adr;

  always_comb begin
    m_adr = '0;
    m_dat = '0;
    m_sel = '0;
    m_we  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        m_adr = wb_adr_i[32*p +: 32];
        m_dat = wb_dat_i[32*p +: 32];
        m_sel = wb_sel_i[4*p +: 4];
        m_we  = wb_we_i[p];
      end
    end
  end

  assign m_idx      = m_adr[ADDR_W+1:2];
  assign unused_adr = ^{m_adr[31:ADDR_W+2], m_adr[1:0]};

  // Single-port RAM: one access per cycle, contents deliberately left unreset.
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_q;
  logic [31:0] rdata;

  always_ff @(posedge clk_i) begin
    if (gnt_any) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++) begin
          if (m_sel[b]) mem_q[m_idx][8*b +: 8] <= m_dat[8*b +: 8];
        end
      end else begin
        rd_q <= mem_q[m_idx];
      end
    end
  end

`ifdef ECAP5_DWBMEM_BRAM_OUTREG_EN
  logic [31:0] rd2_q;
  always_ff @(posedge clk_i) begin
    rd2_q <= rd_q;
  end
  assign rdata = rd2_q;
`else
  assign rdata = rd_q;
`endif

  // Ack pipeline per port; dropping cyc flushes every stage of that port.
  logic [NUM_PORTS-1:0] vld_q [LAT];
  logic [NUM_PORTS-1:0] we_q  [LAT];
  logic [NUM_PORTS-1:0] out_rd;
  logic [NUM_PORTS*32-1:0] dat_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        vld_q[s] <= '0;
        we_q[s]  <= '0;
      end
    end else begin
      rr_q     <= rr_d;
      vld_q[0] <= grant & wb_cyc_i;
      we_q[0]  <= wb_we_i;
      for (int s = 1; s < LAT; s++) begin
        vld_q[s] <= vld_q[s-1] & wb_cyc_i;
        we_q[s]  <= we_q[s-1];
      end
    end
  end

  assign out_rd   = vld_q[LAT-1] & ~we_q[LAT-1];
  assign wb_ack_o = vld_q[LAT-1] & wb_cyc_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dat_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (out_rd[p] && wb_cyc_i[p]) dat_q[32*p +: 32] <= rdata;
      end
    end
  end

  // Present fresh RAM data during a read ack, the held word otherwise.
  always_comb begin
    wb_dat_o = dat_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (out_rd[p]) wb_dat_o[32*p +: 32] = rdata;
    end
  end

endmodule
